uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
- Receive buffer directly downstream of the UART receiver.
- Consumes the receiver's byte-ready interrupt, data and error flags, and returns the single-cycle acknowledge the receiver needs to clear them.
- Stores each byte with its parity and rate (framing) error bits in a circular FIFO.
- Presents a show-ahead read port, fill status and a threshold interrupt to the host/register block.

Parameters:
- ADDR_W, 4, FIFO address width; DEPTH = 2**ADDR_W entries (default 16).

Ports:
- i_clk  input  1  clock.
- i_reset_n  input  1  reset; asynchronous, active-low.
- i_rx_int  input  1  receiver byte-ready interrupt (level, held until acked).
- i_rx_data  input  8  received byte, valid while i_rx_int=1.
- i_parity_err  input  1  receiver parity error flag, valid while i_rx_int=1.
- i_rate_err  input  1  receiver rate/stop-bit error flag, valid while i_rx_int=1.
- o_rx_ack  output  1  acknowledge to receiver; one-cycle pulse.
- i_rd_en  input  1  host pop of head entry.
- o_rd_data  output  8  head byte (show-ahead).
- o_rd_perr  output  1  head entry parity error.
- o_rd_ferr  output  1  head entry rate error.
- o_empty  output  1  FIFO empty.
- o_full  output  1  FIFO full.
- o_count  output  ADDR_W+1  number of stored entries, 0..DEPTH.
- i_thr  input  ADDR_W+1  fill threshold.
- o_thr_int  output  1  fill threshold interrupt.
- o_overrun  output  1  sticky overrun flag.
- i_ovr_clr  input  1  clears o_overrun.
- o_timeout  output  1  character timeout interrupt; tied 0 without the macro.

Behaviour:
- Reset: all outputs 0 except o_empty=1. Reset clears pointers, count, overrun and timeout and forces FSM to IDLE. Storage array is not reset. Reset mid-capture discards the in-flight byte.
- Capture FSM, 2 states:
  - IDLE: on i_rx_int=1, at that edge write {i_rate_err, i_parity_err, i_rx_data} and go to ACK.
  - ACK: o_rx_ack=1 for exactly this cycle; i_rx_int is ignored; always return to IDLE.
  - o_rx_ack is registered (high only in ACK). Minimum capture spacing is 2 cycles.
  - i_rx_int still high in the IDLE cycle after ACK means a new byte, which is captured.
- Write when full, with no simultaneous pop: byte dropped, o_rx_ack still pulsed, o_overrun set.
- Write when full with simultaneous i_rd_en=1: pop and push both occur, no overrun, count stays DEPTH.
- Read: o_rd_data/o_rd_perr/o_rd_ferr always show the head entry. i_rd_en=1 with !o_empty advances the read pointer at the edge. i_rd_en on empty is ignored, with no underflow and no pointer change.
- Pointers are ADDR_W bits and wrap naturally DEPTH-1 -> 0. o_count is a registered up/down counter: +1 on write only, -1 on read only, unchanged on both or neither.
- o_empty = (o_count==0); o_full = (o_count==DEPTH). Both combinational from o_count.
- o_thr_int = (i_thr!=0) && (o_count >= i_thr). Combinational level.
- o_overrun: set on a dropped byte. i_ovr_clr clears it. Set has priority when both occur in the same cycle.

Optional Feature:
- Macro: UART_RX_FIFO_TIMEOUT_EN.
- With macro:
  - Adds parameter TO_CYCLES (default 16'd4000) and a 16-bit idle counter.
  - The counter clears on any FIFO write or successful read, or while o_empty=1. Otherwise it increments, saturating at TO_CYCLES.
  - o_timeout = 1 when counter == TO_CYCLES, held until the next write or read.
- Without macro: no counter; o_timeout constant 0.

Test Plan:
- Single byte: i_rx_int high with data 8'hA5, perr=0, ferr=0 -> o_rx_ack high for exactly 1 cycle, next cycle; o_count=1, o_empty=0, o_rd_data=8'hA5. One i_rd_en pulse -> o_count=0, o_empty=1.
- Back-to-back: i_rx_int re-asserted in the IDLE cycle right after ACK with 8'h3C after 8'h5A -> two acks 2 cycles apart; reads return 8'h5A then 8'h3C.
- Error flags: byte 8'h81 with perr=1, ferr=1 -> head shows o_rd_perr=1, o_rd_ferr=1; next byte 8'h00 with flags 0 shows 0/0 after pop.
- Full/overrun (ADDR_W=4): write 17 bytes 0..16 with no reads -> o_full=1 after the 16th, 17th still acked, o_overrun=1, o_count=16; reads return 0..15 (write pointer wrapped). i_ovr_clr -> o_overrun=0.
- Full with simultaneous pop: FIFO full, i_rd_en coincident with capture edge -> o_overrun stays 0, o_count stays 16, new byte read last. Also i_thr=4: o_thr_int rises when o_count reaches 4 and falls at 3.
- Timeout (macro on, TO_CYCLES=100): 1 byte stored, idle 100 cycles -> o_timeout=1. A pop clears it and it stays 0 while empty. Macro off -> o_timeout stays 0.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver: captures byte + parity/rate error flags, acks the receiver,
// and exposes a show-ahead read port. Optional character timeout under UART_RX_FIFO_TIMEOUT_EN.
module uart_rx_fifo #(
  parameter int ADDR_W = 4
`ifdef UART_RX_FIFO_TIMEOUT_EN
  ,
  parameter logic [15:0] TO_CYCLES = 16'd4000
`endif
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_rx_int,
  input  logic [7:0]        i_rx_data,
  input  logic              i_parity_err,
  input  logic              i_rate_err,
  output logic              o_rx_ack,
  input  logic              i_rd_en,
  output logic [7:0]        o_rd_data,
  output logic              o_rd_perr,
  output logic              o_rd_ferr,
  output logic              o_empty,
  output logic              o_full,
  output logic [ADDR_W:0]   o_count,
  input  logic [ADDR_W:0]   i_thr,
  output logic              o_thr_int,
  output logic              o_overrun,
  input  logic              i_ovr_clr,
  output logic              o_timeout
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACK  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overrun_q, overrun_d;
  logic [9:0]        mem_q [DEPTH];

  logic capture, push, pop;

  // Handshake: receiver holds i_rx_int until it sees o_rx_ack; each IDLE cycle with
  // i_rx_int high is one new byte, and the ACK cycle that follows never captures.
  assign capture = (state_q == ST_IDLE) && i_rx_int;
  assign pop     = i_rd_en && !o_empty;
  assign push    = capture && (!o_full || pop);

  always_comb begin
    state_d = (state_q == ST_IDLE && i_rx_int) ? ST_ACK : ST_IDLE;
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  // Set wins over clear so a drop in the clearing cycle is not lost.
  always_comb begin
    overrun_d = overrun_q;
    if (i_ovr_clr) overrun_d = 1'b0;
    if (capture && o_full && !pop) overrun_d = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= {i_rate_err, i_parity_err, i_rx_data};
  end

  assign o_rx_ack  = (state_q == ST_ACK);
  assign o_rd_data = mem_q[rd_ptr_q][7:0];
  assign o_rd_perr = mem_q[rd_ptr_q][8];
  assign o_rd_ferr = mem_q[rd_ptr_q][9];
  assign o_count   = count_q;
  assign o_empty   = (count_q == '0);
  assign o_full    = (count_q == (ADDR_W+1)'(DEPTH));
  assign o_thr_int = (i_thr != '0) && (count_q >= i_thr);
  assign o_overrun = overrun_q;

`ifdef UART_RX_FIFO_TIMEOUT_EN
  logic [15:0] idle_cnt_q;

  // Counts idle cycles with data waiting; saturates so o_timeout holds until activity.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      idle_cnt_q <= '0;
    end else if (push || pop || o_empty) begin
      idle_cnt_q <= '0;
    end else if (idle_cnt_q != TO_CYCLES) begin
      idle_cnt_q <= idle_cnt_q + 16'd1;
    end
  end

  assign o_timeout = (idle_cnt_q == TO_CYCLES);
`else
  assign o_timeout = 1'b0;
`endif

endmodule
